// File: rtl/bridge_keypad_pkg.sv
// Key indices, PS/2 set-2 scan codes and the scan-code lookup for the Bridge
// Companion keypad.
package bridge_keypad_pkg;

    localparam int unsigned NUM_KEYS = 12;

    localparam logic [3:0] KEY_PASS          = 4'd0;
    localparam logic [3:0] KEY_SPADES        = 4'd1;
    localparam logic [3:0] KEY_CLUBS         = 4'd2;
    localparam logic [3:0] KEY_RDBL          = 4'd3;
    localparam logic [3:0] KEY_NT            = 4'd4;
    localparam logic [3:0] KEY_HEARTS_UP     = 4'd5;
    localparam logic [3:0] KEY_PLAY_YES      = 4'd6;
    localparam logic [3:0] KEY_BACK          = 4'd7;
    localparam logic [3:0] KEY_DBL           = 4'd8;
    localparam logic [3:0] KEY_DIAMONDS_DOWN = 4'd9;
    localparam logic [3:0] KEY_START         = 4'd10;
    localparam logic [3:0] KEY_PLAY_NO       = 4'd11;

    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_Z     = 8'h1A;
    localparam logic [7:0] SC_V     = 8'h2A;
    localparam logic [7:0] SC_F     = 8'h2B;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_X     = 8'h22;
    localparam logic [7:0] SC_LCTRL = 8'h14;
    localparam logic [7:0] SC_BKSP  = 8'h66;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_C     = 8'h21;
    localparam logic [7:0] SC_1     = 8'h16;
    localparam logic [7:0] SC_LALT  = 8'h11;

    // Returns {valid, index}; valid is 0 for codes outside the keypad map.
    function automatic logic [4:0] code_to_index(input logic [7:0] code);
        logic [4:0] res;
        res = 5'b1_0000;
        case (code)
            SC_A:     res[3:0] = KEY_PASS;
            SC_Z:     res[3:0] = KEY_SPADES;
            SC_V:     res[3:0] = KEY_CLUBS;
            SC_F:     res[3:0] = KEY_RDBL;
            SC_S:     res[3:0] = KEY_NT;
            SC_X:     res[3:0] = KEY_HEARTS_UP;
            SC_LCTRL: res[3:0] = KEY_PLAY_YES;
            SC_BKSP:  res[3:0] = KEY_BACK;
            SC_D:     res[3:0] = KEY_DBL;
            SC_C:     res[3:0] = KEY_DIAMONDS_DOWN;
            SC_1:     res[3:0] = KEY_START;
            SC_LALT:  res[3:0] = KEY_PLAY_NO;
            default:  res      = 5'b0_0000;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/bridge_keypad_if.sv
// Signal bundle between hps_io/system (master) and the keypad bridge (slave).
interface bridge_keypad_if;
    import bridge_keypad_pkg::*;

    logic [10:0]         ps2_key;
    logic                vblank;
    logic [15:0]         joystick;
    logic [NUM_KEYS-1:0] inputs;
    logic                key_event;
    logic [3:0]          key_index;
    logic                key_pressed;

    modport master (
        output ps2_key, vblank, joystick,
        input  inputs, key_event, key_index, key_pressed
    );

    modport slave (
        input  ps2_key, vblank, joystick,
        output inputs, key_event, key_index, key_pressed
    );

endinterface

// File: rtl/bridge_key_hold.sv
// Per-key press state plus a vblank-tick hold counter that stretches a release
// by HOLD_TICKS frames; the stretched level is registered.
module bridge_key_hold #(
    parameter int unsigned HOLD_TICKS = 3
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_press,
    input  logic i_release,
    input  logic i_tick,
    output logic o_level
);

    localparam int unsigned CntW = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;
    localparam logic [CntW-1:0] Reload = CntW'(HOLD_TICKS);

    logic            r_key_down, w_key_down;
    logic [CntW-1:0] r_hold_cnt, w_hold_cnt;
    logic            r_level;

    // A press reloads the counter and beats a same-cycle tick.
    always_comb begin
        w_key_down = r_key_down;
        w_hold_cnt = r_hold_cnt;
        if (i_press) begin
            w_key_down = 1'b1;
            w_hold_cnt = Reload;
        end else begin
            if (i_release) w_key_down = 1'b0;
            if (i_tick && !r_key_down && (r_hold_cnt != '0)) begin
                w_hold_cnt = r_hold_cnt - CntW'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_key_down <= 1'b0;
            r_hold_cnt <= '0;
            r_level    <= 1'b0;
        end else begin
            r_key_down <= w_key_down;
            r_hold_cnt <= w_hold_cnt;
            r_level    <= w_key_down | (w_hold_cnt != '0);
        end
    end

    assign o_level = r_level;

endmodule

// File: rtl/bridge_keypad.sv
// PS/2 key stream to Bridge Companion button vector with per-frame stretching.
// Optional: define BRIDGE_KEYPAD_JOYSTICK_EN to OR joystick_0 bits into inputs.
module bridge_keypad
    import bridge_keypad_pkg::*;
#(
    parameter int unsigned HOLD_TICKS = 3,
    parameter int unsigned NUM_KEYS   = 12
) (
    input  logic            i_clk,
    input  logic            i_reset,
    bridge_keypad_if.slave  io_kp
);

    if (NUM_KEYS != bridge_keypad_pkg::NUM_KEYS) begin : g_num_keys_check
        $error("bridge_keypad: NUM_KEYS does not match the package key map");
    end

    logic                r_old_toggle;
    logic                r_vblank_prev;
    logic                r_evt_valid;
    logic                r_evt_press;
    logic [3:0]          r_evt_idx;
    logic                r_key_event;
    logic [3:0]          r_key_index;
    logic                r_key_pressed;
    logic [4:0]          w_map;
    logic                w_new_evt;
    logic                w_tick;
    logic [NUM_KEYS-1:0] w_level;
    logic [NUM_KEYS-1:0] r_joy;

    assign w_map     = code_to_index(io_kp.ps2_key[7:0]);
    assign w_new_evt = (io_kp.ps2_key[10] != r_old_toggle) && !io_kp.ps2_key[8] && w_map[4];
    assign w_tick    = io_kp.vblank && !r_vblank_prev;

    // Edge stage: decoded event lands in r_evt_* one cycle after the toggle flips.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_old_toggle  <= io_kp.ps2_key[10];
            r_vblank_prev <= io_kp.vblank;
            r_evt_valid   <= 1'b0;
            r_evt_press   <= 1'b0;
            r_evt_idx     <= 4'd0;
            r_key_event   <= 1'b0;
            r_key_index   <= 4'd0;
            r_key_pressed <= 1'b0;
        end else begin
            r_old_toggle  <= io_kp.ps2_key[10];
            r_vblank_prev <= io_kp.vblank;
            r_evt_valid   <= w_new_evt;
            if (w_new_evt) begin
                r_evt_press <= io_kp.ps2_key[9];
                r_evt_idx   <= w_map[3:0];
            end
            r_key_event <= r_evt_valid;
            if (r_evt_valid) begin
                r_key_index   <= r_evt_idx;
                r_key_pressed <= r_evt_press;
            end
        end
    end

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        logic w_hit;
        assign w_hit = r_evt_valid && (r_evt_idx == 4'(k));

        bridge_key_hold #(
            .HOLD_TICKS (HOLD_TICKS)
        ) u_hold (
            .i_clk     (i_clk),
            .i_reset   (i_reset),
            .i_press   (w_hit && r_evt_press),
            .i_release (w_hit && !r_evt_press),
            .i_tick    (w_tick),
            .o_level   (w_level[k])
        );
    end

`ifdef BRIDGE_KEYPAD_JOYSTICK_EN
    logic [NUM_KEYS-1:0] w_joy_map;

    always_comb begin
        w_joy_map                    = '0;
        w_joy_map[KEY_HEARTS_UP]     = io_kp.joystick[3];
        w_joy_map[KEY_DIAMONDS_DOWN] = io_kp.joystick[2];
        w_joy_map[KEY_PLAY_YES]      = io_kp.joystick[4];
        w_joy_map[KEY_PLAY_NO]       = io_kp.joystick[5];
        w_joy_map[KEY_PASS]          = io_kp.joystick[6];
        w_joy_map[KEY_START]         = io_kp.joystick[7];
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) r_joy <= '0;
        else         r_joy <= w_joy_map;
    end
`else
    logic w_unused_joy;
    assign w_unused_joy = ^io_kp.joystick;
    assign r_joy        = '0;
`endif

    assign io_kp.inputs      = w_level | r_joy;
    assign io_kp.key_event   = r_key_event;
    assign io_kp.key_index   = r_key_index;
    assign io_kp.key_pressed = r_key_pressed;

endmodule

// File: tb/tb_bridge_keypad.sv
// Directed self-checking bench for bridge_keypad (HOLD_TICKS = 3).
module tb_bridge_keypad;

    logic clk;
    logic reset;
    int   n_pass;
    int   n_total;

    bridge_keypad_if kp ();

    bridge_keypad #(
        .HOLD_TICKS (3),
        .NUM_KEYS   (12)
    ) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .io_kp   (kp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic send(input logic press, input logic ext, input logic [7:0] code);
        kp.ps2_key = {~kp.ps2_key[10], press, ext, code};
    endtask

    task automatic vb_pulse();
        kp.vblank = 1'b1;
        step(1);
        kp.vblank = 1'b0;
        step(1);
    endtask

    initial begin
        n_pass      = 0;
        n_total     = 0;
        reset       = 1'b1;
        kp.ps2_key  = 11'h400;
        kp.vblank   = 1'b0;
        kp.joystick = 16'h0000;

        // Reset with toggle already high: no event on exit.
        step(3);
        chk("reset_inputs", 32'(kp.inputs), 32'h000);
        chk("reset_event", 32'(kp.key_event), 32'h0);
        chk("reset_index", 32'(kp.key_index), 32'h0);
        chk("reset_pressed", 32'(kp.key_pressed), 32'h0);
        reset = 1'b0;
        step(2);
        chk("reset_exit_event", 32'(kp.key_event), 32'h0);

        // Press A: two-cycle latency.
        send(1'b1, 1'b0, 8'h1C);
        step(1);
        chk("a_press_early", 32'(kp.key_event), 32'h0);
        chk("a_press_early_in", 32'(kp.inputs), 32'h000);
        step(1);
        chk("a_press_event", 32'(kp.key_event), 32'h1);
        chk("a_press_index", 32'(kp.key_index), 32'h0);
        chk("a_press_dir", 32'(kp.key_pressed), 32'h1);
        chk("a_press_inputs", 32'(kp.inputs), 32'h001);
        step(1);
        chk("a_event_oneshot", 32'(kp.key_event), 32'h0);

        // Release A: held for 3 ticks.
        send(1'b0, 1'b0, 8'h1C);
        step(2);
        chk("a_rel_event", 32'(kp.key_event), 32'h1);
        chk("a_rel_dir", 32'(kp.key_pressed), 32'h0);
        chk("a_rel_inputs", 32'(kp.inputs), 32'h001);
        vb_pulse();
        chk("a_hold_t1", 32'(kp.inputs), 32'h001);
        vb_pulse();
        chk("a_hold_t2", 32'(kp.inputs), 32'h001);
        vb_pulse();
        chk("a_hold_t3", 32'(kp.inputs), 32'h000);

        // Short tap of '1' (start, index 10).
        send(1'b1, 1'b0, 8'h16);
        step(1);
        send(1'b0, 1'b0, 8'h16);
        step(2);
        chk("tap_rel_index", 32'(kp.key_index), 32'd10);
        chk("tap_inputs", 32'(kp.inputs), 32'h400);
        vb_pulse();
        chk("tap_t1", 32'(kp.inputs), 32'h400);
        vb_pulse();
        chk("tap_t2", 32'(kp.inputs), 32'h400);
        vb_pulse();
        chk("tap_t3", 32'(kp.inputs), 32'h000);

        // X tapped, two ticks leave hold_cnt=1; then re-press on a tick edge.
        send(1'b1, 1'b0, 8'h22);
        step(1);
        send(1'b0, 1'b0, 8'h22);
        step(2);
        vb_pulse();
        vb_pulse();
        chk("x_cnt1", 32'(kp.inputs), 32'h020);
        send(1'b1, 1'b0, 8'h22);
        step(1);
        kp.vblank = 1'b1;
        step(1);
        kp.vblank = 1'b0;
        chk("x_press_on_tick", 32'(kp.inputs), 32'h020);
        send(1'b0, 1'b0, 8'h22);
        step(2);
        chk("x_rel", 32'(kp.inputs), 32'h020);
        vb_pulse();
        vb_pulse();
        chk("x_reload_t2", 32'(kp.inputs), 32'h020);
        vb_pulse();
        chk("x_reload_t3", 32'(kp.inputs), 32'h000);

        // Extended and unmapped codes are ignored.
        send(1'b1, 1'b1, 8'h14);
        step(2);
        chk("ext_event", 32'(kp.key_event), 32'h0);
        chk("ext_inputs", 32'(kp.inputs), 32'h000);
        send(1'b1, 1'b0, 8'h29);
        step(2);
        chk("unmapped_event", 32'(kp.key_event), 32'h0);
        chk("unmapped_inputs", 32'(kp.inputs), 32'h000);
        chk("unmapped_index", 32'(kp.key_index), 32'd5);

        // A and Z together.
        send(1'b1, 1'b0, 8'h1C);
        step(1);
        send(1'b1, 1'b0, 8'h1A);
        step(2);
        chk("az_inputs", 32'(kp.inputs), 32'h003);
        chk("az_index", 32'(kp.key_index), 32'd1);

        // Reset while both are only being stretched.
        send(1'b0, 1'b0, 8'h1C);
        step(1);
        send(1'b0, 1'b0, 8'h1A);
        step(2);
        chk("az_held", 32'(kp.inputs), 32'h003);
        reset = 1'b1;
        step(1);
        chk("mid_hold_reset", 32'(kp.inputs), 32'h000);
        reset = 1'b0;
        step(2);
        chk("mid_hold_exit_event", 32'(kp.key_event), 32'h0);
        chk("mid_hold_exit_inputs", 32'(kp.inputs), 32'h000);

`ifdef BRIDGE_KEYPAD_JOYSTICK_EN
        kp.joystick = 16'h0008;
        step(1);
        chk("joy_up", 32'(kp.inputs), 32'h020);
        chk("joy_no_event", 32'(kp.key_event), 32'h0);
        kp.joystick = 16'h0000;
        step(1);
        chk("joy_clear", 32'(kp.inputs), 32'h000);
        kp.joystick = 16'h00F4;
        step(1);
        chk("joy_map", 32'(kp.inputs), 32'hE41);
        kp.joystick = 16'h0000;
        step(1);
        chk("joy_map_clear", 32'(kp.inputs), 32'h000);
`else
        kp.joystick = 16'hFFFF;
        step(2);
        chk("joy_ignored", 32'(kp.inputs), 32'h000);
        kp.joystick = 16'h0000;
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/bridge_keypad.md
Name: bridge_keypad

Overview:
- Converts the PS/2 key-event stream from hps_io into the 12-bit active-high Bridge Companion button vector that the system block consumes as `inputs`.
- Sits between hps_io and system, in the emu top level.
- Stretches every keypress to a minimum number of video frames, so short taps are never missed by the game's once-per-frame keypad poll.
- Emits a one-cycle event pulse with the key index, for debug and OSD use.

Parameters:
- HOLD_TICKS, 3: minimum number of vblank rising edges a key stays reported after release. 0 = no stretch (pure level passthrough).
- NUM_KEYS, 12: button count. Fixed by the hardware; a parameter only so the package constant can be checked against it.

Ports:
- clk  in  1  system clock (clk_sys)
- reset  in  1  synchronous, active-high
- ps2_key  in  11  hps_io key word: [10] toggle, [9] pressed, [8] extended, [7:0] scan code
- vblank  in  1  video vblank level; its rising edge is the hold tick
- joystick  in  16  hps_io joystick_0. Used only when the optional feature is compiled in.
- inputs  out  12  button vector to system. Bit order: 11 play_no … 0 pass.
- key_event  out  1  one-cycle pulse on a mapped press or release
- key_index  out  4  index of the last mapped event
- key_pressed  out  1  direction of the last mapped event (1 = press)

Behaviour:
Key map, index: code.
- 0 pass: 1C (A)
- 1 spades: 1A (Z)
- 2 clubs: 2A (V)
- 3 rdbl: 2B (F)
- 4 NT: 1B (S)
- 5 hearts_up: 22 (X)
- 6 play_yes: 14 (LCtrl)
- 7 back: 66 (Backspace)
- 8 dbl: 23 (D)
- 9 diamonds_down: 21 (C)
- 10 start: 16 (1)
- 11 play_no: 11 (LAlt)

Reset:
- key_down, hold_cnt, inputs, key_event, key_index and key_pressed all go to 0.
- old_toggle is loaded from ps2_key[10], so no spurious event is generated on reset exit.

Event detection:
- An event occurs when ps2_key[10] differs from old_toggle; old_toggle is updated every cycle.
- Events with ps2_key[8]=1 (extended: RCtrl, RAlt) are ignored.
- Unmapped codes are ignored: no key_event pulse, no state change.

Press of key i:
- key_down[i] <= 1.
- hold_cnt[i] <= HOLD_TICKS.
- A repeated press (typematic) reloads hold_cnt and is otherwise a no-op.

Release of key i:
- key_down[i] <= 0.
- hold_cnt[i] is untouched.
- A release while key_down is already 0 is a no-op apart from key_event.

Tick and hold counters:
- tick is the rising edge of vblank, detected with a registered previous sample.
- On tick, every hold_cnt[i] != 0 with key_down[i] = 0 decrements by 1.
- Counters saturate at 0 and never wrap.
- hold_cnt width is $clog2(HOLD_TICKS+1), minimum 1 bit.
- If a press event and a tick land in the same cycle for the same key, the press wins: reload, no decrement.

Output:
- inputs[i] is registered: key_down[i] | (hold_cnt[i] != 0).
- Latency from the cycle the toggle change is presented to inputs changing: 2 cycles (edge register, then output register).
- key_event, key_index and key_pressed are valid in the same cycle that inputs updates.
- After a tap of fewer than one frame, inputs[i] stays high until HOLD_TICKS ticks have elapsed after release.

Reset mid-hold: all stretched keys clear in the next cycle.

Optional Feature:
- Macro: BRIDGE_KEYPAD_JOYSTICK_EN.
- Defined: joystick bits are registered once and ORed into inputs after the hold logic. They are not stretched and do not generate key_event. Mapping:
  - [3] up → 5
  - [2] down → 9
  - [4] → 6
  - [5] → 11
  - [6] → 0
  - [7] → 10
- Undefined: the joystick port is unused and carries no logic.

Decomposition:
- Package bridge_keypad_pkg holds:
  - KEY_* index localparams (0..11)
  - SC_* scan-code localparams
  - NUM_KEYS
  - a function code_to_index returning {valid, index[3:0]}
- Sub-module bridge_key_hold, instantiated once per key: holds key_down and hold_cnt with press/release/tick inputs, and drives the stretched level out.

Test Plan:
- Reset held 3 cycles with ps2_key[10]=1 → inputs=000, no key_event on reset release.
- Toggle ps2_key with pressed=1, code 1C → key_event high on cycle +2, key_index=0, inputs=001. Release plus 3 vblank rising edges → inputs=001 until the 3rd edge, then 000.
- Press and release of 16 (1) within one frame, HOLD_TICKS=3 → inputs[10] high for exactly 3 ticks.
- Press of 22 coincident with a vblank rising edge while hold_cnt=1 → hold_cnt=3, inputs[5] stays 1.
- Extended E0 14 press and unmapped code 29 → no key_event, inputs unchanged. Then A+Z pressed together → inputs=003.
- With BRIDGE_KEYPAD_JOYSTICK_EN: joystick=0x0008 → inputs[5]=1 after 1 cycle, no key_event. Clearing it → 0 the next cycle, with no stretch.
